grey_dec: RTL
=============

Name: grey_dec

Overview:
- Receive-side decoder for a chain of 5-bit grey-coded decimal digit counters.
- Samples the grey digit bus, which is asynchronous to i_clk because the counters clock on their own count strobe.
- Synchronises and stability-filters the bus, validates each digit code, and converts it to BCD.
- Delivers changed values to a consumer over a valid/ack handshake, with sticky error reporting.

Parameters:
- pDIGITS, 2: number of grey digits on the input bus, legal range 1..8.
- pSTABLE, 2: number of consecutive identical synchronised samples needed before a word is accepted, legal range 1..15.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_grey, in, 5*pDIGITS: grey digit bus. Digit 0 (least significant) is on [4:0]. Asynchronous to i_clk.
- i_ack, in, 1: consumer acknowledge. Sampled only while o_valid=1.
- o_valid, out, 1: o_bcd holds an unacknowledged new value.
- o_bcd, out, 4*pDIGITS: decoded BCD digits. Digit 0 is on [3:0].
- o_ovr, out, 1: one-cycle pulse; a pending value was overwritten before ack.
- o_err, out, 1: sticky; an illegal grey code was accepted.
- o_step_err, out, 1: sticky; a non-successor digit transition was seen (optional feature).

Behaviour:
- Code table, value=code: 0=11000, 1=11001, 2=10001, 3=10011, 4=00011, 5=00111, 6=00110, 7=01110, 8=01100, 9=11100. Every other 5-bit code is illegal.
- Reset (async assert, release on i_clk):
  - Synchroniser stages and the previous-sample register load 11000 per digit.
  - Stability counter = 0; held word r_acc = all digits 11000.
  - o_bcd = 0, o_valid = 0, o_ovr = 0, o_err = 0, o_step_err = 0.
  - FSM = S_IDLE.
- Synchroniser: two flops per bit; no other logic on the first stage.
- Stability filter:
  - Compare synchronised word S with the previous-cycle S. Equal: counter increments, saturating at pSTABLE. Different: counter clears to 0.
  - S is accepted in the cycle the counter first reaches pSTABLE-1 while equal. With pSTABLE=1, any S equal to the previous S is accepted.
  - An accepted word is not re-accepted until S changes.
  - Latency, input change to o_valid: 2 sync + pSTABLE + 1 cycles.
- Validation, on each accepted word:
  - Any illegal digit: set o_err; discard the whole word; r_acc and o_bcd unchanged.
  - All digits legal and word == r_acc: no action.
  - All digits legal and word != r_acc: update r_acc and emit an event.
- FSM:
  - S_IDLE, o_valid=0. On an event: load o_bcd with the decoded word, o_valid=1 next cycle, go to S_PEND.
  - S_PEND, o_valid=1, o_bcd frozen.
    - i_ack=1 with no event: o_valid=0, go to S_IDLE.
    - Event with i_ack=0: o_bcd loads the new value (latest wins), o_ovr pulses for one cycle, stay in S_PEND.
    - Event with i_ack=1 in the same cycle: o_bcd loads the new value, o_valid stays 1, no o_ovr, stay in S_PEND.
- i_ack in S_IDLE is ignored.
- o_err and o_step_err clear only on reset.
- Reset mid-transfer: o_valid drops asynchronously; the pending value is lost.
- Wrap-around: 9->0 on digit 0 together with a carry on digit 1 is an ordinary event, e.g. 19 -> 20.

Optional Feature:
- Macro: GREY_DEC_STEP_CHECK_EN.
- Defined: on each event, every digit must equal its previous r_acc value or that value's successor (9's successor is 0).
  - Any other transition sets o_step_err.
  - The word is still published, so o_step_err flags undersampling only.
- Not defined: no step logic; o_step_err tied to 0.

Test Plan:
- Reset, hold i_grey=11000_11000 -> o_valid stays 0, o_bcd=0x00, no errors.
- i_grey -> 11000_11001 (01), pSTABLE=2 -> o_valid rises 5 cycles later with o_bcd=0x01; i_ack=1 one cycle -> o_valid=0.
- Step digits through 08, 09, then 10 (digit1=11001, digit0=11000) with ack after each -> o_bcd sequence 0x08, 0x09, 0x10; o_step_err=0 with GREY_DEC_STEP_CHECK_EN defined.
- Publish 0x03, withhold ack, apply 04 then 05 -> o_ovr pulses once per overwrite, o_bcd=0x05; an event in the ack cycle -> o_valid stays 1, no o_ovr.
- Apply illegal 10101 on digit 0 for 6 cycles -> o_err=1, o_bcd unchanged; later legal 07 -> published 0x07, o_err stays 1.
- Toggle a bit every cycle for 10 cycles -> no acceptance, no o_valid. With macro defined, jump 02 -> 05 -> o_bcd=0x05 and o_step_err=1. Assert i_rst mid-S_PEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/grey_dec.sv
// rtl/grey_dec.sv - grey-coded decimal digit bus decoder with valid/ack output (optional GREY_DEC_STEP_CHECK_EN)
module grey_dec #(
    parameter int pDIGITS = 2,
    parameter int pSTABLE = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [5*pDIGITS-1:0]   i_grey,
    input  logic                   i_ack,
    output logic                   o_valid,
    output logic [4*pDIGITS-1:0]   o_bcd,
    output logic                   o_ovr,
    output logic                   o_err,
    output logic                   o_step_err
);

    localparam logic [4:0]           ZERO_CODE  = 5'b11000;
    localparam logic [5*pDIGITS-1:0] ZERO_WORD  = {pDIGITS{ZERO_CODE}};
    localparam logic [3:0]           STABLE_MAX = 4'(pSTABLE);
    localparam logic [3:0]           STABLE_ACC = 4'(pSTABLE - 1);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    // Returns {legal, value}; illegal codes decode to value 0.
    function automatic logic [4:0] decode_digit(input logic [4:0] code);
        case (code)
            5'b11000: decode_digit = {1'b1, 4'd0};
            5'b11001: decode_digit = {1'b1, 4'd1};
            5'b10001: decode_digit = {1'b1, 4'd2};
            5'b10011: decode_digit = {1'b1, 4'd3};
            5'b00011: decode_digit = {1'b1, 4'd4};
            5'b00111: decode_digit = {1'b1, 4'd5};
            5'b00110: decode_digit = {1'b1, 4'd6};
            5'b01110: decode_digit = {1'b1, 4'd7};
            5'b01100: decode_digit = {1'b1, 4'd8};
            5'b11100: decode_digit = {1'b1, 4'd9};
            default:  decode_digit = {1'b0, 4'd0};
        endcase
    endfunction

    logic [5*pDIGITS-1:0] sync1, sync2, prev, r_acc;
    logic [3:0]           cnt;
    logic                 same, accept, all_legal, evt, step_bad;
    logic [4*pDIGITS-1:0] dec_bcd;
    state_t               state, next_state;
    logic                 load, ovr_set;

    // Two-flop synchroniser, previous-sample register and stability counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= ZERO_WORD;
            sync2 <= ZERO_WORD;
            prev  <= ZERO_WORD;
            cnt   <= 4'd0;
        end else begin
            sync1 <= i_grey;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev)
                cnt <= 4'd0;
            else if (cnt != STABLE_MAX)
                cnt <= cnt + 4'd1;
        end
    end

    // The counter passes pSTABLE-1 only once per stable run, so a word is accepted once.
    assign same   = (sync2 == prev);
    assign accept = same && (cnt == STABLE_ACC);

    // Decode every digit of the synchronised word and flag an event on a legal change.
    always_comb begin
        logic [4:0] d;
        d         = 5'd0;
        all_legal = 1'b1;
        dec_bcd   = '0;
        for (int i = 0; i < pDIGITS; i++) begin
            d                 = decode_digit(sync2[5*i +: 5]);
            all_legal         = all_legal & d[4];
            dec_bcd[4*i +: 4] = d[3:0];
        end
        evt = accept && all_legal && (sync2 != r_acc);
    end

    // Held word tracking and sticky illegal-code flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= ZERO_WORD;
            o_err <= 1'b0;
        end else begin
            if (evt)
                r_acc <= sync2;
            if (accept && !all_legal)
                o_err <= 1'b1;
        end
    end

`ifdef GREY_DEC_STEP_CHECK_EN
    // Each digit may only hold or advance by one (9 wraps to 0) between events.
    always_comb begin
        logic [4:0] o_d, n_d;
        o_d      = 5'd0;
        n_d      = 5'd0;
        step_bad = 1'b0;
        for (int i = 0; i < pDIGITS; i++) begin
            o_d = decode_digit(r_acc[5*i +: 5]);
            n_d = decode_digit(sync2[5*i +: 5]);
            if (!((n_d[3:0] == o_d[3:0]) ||
                  (n_d[3:0] == ((o_d[3:0] == 4'd9) ? 4'd0 : o_d[3:0] + 4'd1))))
                step_bad = 1'b1;
        end
    end

    // Sticky undersampling flag; the word itself is still published.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_step_err <= 1'b0;
        else if (evt && step_bad)
            o_step_err <= 1'b1;
    end
`else
    assign step_bad   = 1'b0;
    assign o_step_err = 1'b0;
`endif

    // Handshake next-state: events always load (latest wins); ack without event releases.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (evt) begin
                    load       = 1'b1;
                    next_state = S_PEND;
                end
            end
            S_PEND: begin
                if (evt) begin
                    load    = 1'b1;
                    ovr_set = !i_ack;
                end else if (i_ack) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake state, output data register and overwrite pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            o_bcd <= '0;
            o_ovr <= 1'b0;
        end else begin
            state <= next_state;
            o_ovr <= ovr_set;
            if (load)
                o_bcd <= dec_bcd;
        end
    end

    assign o_valid = (state == S_PEND);

endmodule
